// File: rtl/mutative_reconfig_engine_pkg.sv
// Shared types for the mutative cache flush/reconfiguration engine.
package mutative_reconfig_engine_pkg;

   typedef enum logic [1:0] {
      OpResize     = 2'd0,
      OpClean      = 2'd1,
      OpInvalidate = 2'd2,
      OpCleanInv   = 2'd3
   } flush_op_t;

   typedef logic [2:0] reconfig_state_t;

   localparam reconfig_state_t StIdle = 3'd0;
   localparam reconfig_state_t StRd   = 3'd1;
   localparam reconfig_state_t StCap  = 3'd2;
   localparam reconfig_state_t StScan = 3'd3;
   localparam reconfig_state_t StWb   = 3'd4;
   localparam reconfig_state_t StClr  = 3'd5;
   localparam reconfig_state_t StDone = 3'd6;

   // Width needed to hold log2(ways); never narrower than one bit.
   function automatic int unsigned setup_bits(input int unsigned ways);
      int unsigned b;
      b = $clog2($clog2(ways) + 1);
      return (b == 0) ? 1 : b;
   endfunction

endpackage

// File: rtl/mutative_way_prio_enc.sv
// Lowest-set-bit priority encoder across the cache ways.
module mutative_way_prio_enc #(
   parameter int unsigned  WAYS     = 8,
   localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [WAYS-1:0]     in_i,
   output logic [WAY_BITS-1:0] idx_o,
   output logic                any_o
);

   // Scan from the top so the lowest set bit is written last and wins.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = int'(WAYS) - 1; i >= 0; i--) begin
         if (in_i[i]) begin
            idx_o = WAY_BITS'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mutative_reconfig_engine.sv
// Flush/reconfiguration engine: walks every set, writes back dirty lines, clears state bits.
module mutative_reconfig_engine
   import mutative_reconfig_engine_pkg::*;
#(
   parameter int unsigned  ADDR_WIDTH  = 32,
   parameter int unsigned  WAYS        = 8,
   parameter int unsigned  SETS        = 16,
   parameter int unsigned  LINE_BITS   = 256,
   parameter int unsigned  RESET_SETUP = 0,
   localparam int unsigned SETUP_BITS  = setup_bits(WAYS),
   localparam int unsigned SET_BITS    = $clog2(SETS),
   localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8),
   localparam int unsigned TAG_BITS    = ADDR_WIDTH - SET_BITS - OFFSET_BITS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [1:0]                cfg_op,
   input  logic [SETUP_BITS-1:0]     cfg_setup,
   output logic [SETUP_BITS-1:0]     setup,
   output logic                      flush_stall,
   output logic                      done,
   output logic [SET_BITS-1:0]       arr_set,
   output logic                      arr_rd,
   input  logic [WAYS-1:0]           arr_valid,
   input  logic [WAYS-1:0]           arr_dirty,
   input  logic [WAYS*TAG_BITS-1:0]  arr_tag,
   input  logic [WAYS*LINE_BITS-1:0] arr_data,
   output logic [WAYS-1:0]           arr_clr_valid,
   output logic [WAYS-1:0]           arr_clr_dirty,
   output logic [ADDR_WIDTH-1:0]     dfp_addr,
   output logic                      dfp_write,
   output logic [LINE_BITS-1:0]      dfp_wdata,
   input  logic                      dfp_resp
);

   localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [SETUP_BITS-1:0] MaxSetup = SETUP_BITS'($clog2(WAYS));

   reconfig_state_t            state_q, state_d;
   flush_op_t                  op_q, op_d;
   logic [SETUP_BITS-1:0]      tgt_q, tgt_d;
   logic [SETUP_BITS-1:0]      setup_q, setup_d;
   logic [SET_BITS-1:0]        set_cnt_q, set_cnt_d;
   logic [WAYS-1:0]            valid_q, valid_d;
   logic [WAYS-1:0]            dirty_q, dirty_d;
   logic [WAYS-1:0]            pend_q, pend_d;
   logic [WAYS*TAG_BITS-1:0]   tag_q, tag_d;
   logic [WAYS*LINE_BITS-1:0]  data_q, data_d;
   logic [WAY_BITS-1:0]        wb_way_q, wb_way_d;

   logic [WAY_BITS-1:0]        pend_idx;
   logic                       pend_any;
   logic [SETUP_BITS-1:0]      cfg_setup_clamped;

   assign cfg_setup_clamped = (cfg_setup > MaxSetup) ? MaxSetup : cfg_setup;

   mutative_way_prio_enc #(
      .WAYS(WAYS)
   ) u_prio (
      .in_i (pend_q),
      .idx_o(pend_idx),
      .any_o(pend_any)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      tgt_d     = tgt_q;
      setup_d   = setup_q;
      set_cnt_d = set_cnt_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      pend_d    = pend_q;
      tag_d     = tag_q;
      data_d    = data_q;
      wb_way_d  = wb_way_q;
      case (state_q)
         StIdle: begin
            if (cfg_valid) begin
               op_d      = flush_op_t'(cfg_op);
               tgt_d     = cfg_setup_clamped;
               set_cnt_d = '0;
               // A resize to the current setting has nothing to flush.
               if (flush_op_t'(cfg_op) == OpResize && cfg_setup_clamped == setup_q) begin
                  state_d = StDone;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: state_d = StCap;
         StCap: begin
            valid_d = arr_valid;
            dirty_d = arr_dirty;
            tag_d   = arr_tag;
            data_d  = arr_data;
            pend_d  = (op_q == OpInvalidate) ? '0 : (arr_dirty & arr_valid);
            state_d = StScan;
         end
         StScan: begin
            if (pend_any) begin
               wb_way_d = pend_idx;
               state_d  = StWb;
            end else begin
               state_d = StClr;
            end
         end
         StWb: begin
            if (dfp_resp) begin
               pend_d[wb_way_q] = 1'b0;
               state_d          = StScan;
            end
         end
         StClr: begin
            if (set_cnt_q == SET_BITS'(SETS - 1)) begin
               if (op_q == OpResize) setup_d = tgt_q;
               state_d = StDone;
            end else begin
               set_cnt_d = set_cnt_q + 1'b1;
               state_d   = StRd;
            end
         end
         StDone: begin
            set_cnt_d = '0;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cfg_ready     = (state_q == StIdle);
      flush_stall   = (state_q != StIdle);
      done          = (state_q == StDone);
      arr_rd        = (state_q == StRd);
      arr_set       = set_cnt_q;
      setup         = setup_q;
      dfp_write     = (state_q == StWb);
      dfp_addr      = '0;
      dfp_wdata     = '0;
      arr_clr_valid = '0;
      arr_clr_dirty = '0;
      if (state_q == StWb) begin
         dfp_addr  = {tag_q[32'(wb_way_q) * TAG_BITS +: TAG_BITS], set_cnt_q,
                      {OFFSET_BITS{1'b0}}};
         dfp_wdata = data_q[32'(wb_way_q) * LINE_BITS +: LINE_BITS];
      end
      if (state_q == StClr) begin
         if (op_q != OpClean)      arr_clr_valid = valid_q;
         if (op_q != OpInvalidate) arr_clr_dirty = dirty_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= OpResize;
         tgt_q     <= '0;
         setup_q   <= SETUP_BITS'(RESET_SETUP);
         set_cnt_q <= '0;
         valid_q   <= '0;
         dirty_q   <= '0;
         pend_q    <= '0;
         tag_q     <= '0;
         data_q    <= '0;
         wb_way_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         tgt_q     <= tgt_d;
         setup_q   <= setup_d;
         set_cnt_q <= set_cnt_d;
         valid_q   <= valid_d;
         dirty_q   <= dirty_d;
         pend_q    <= pend_d;
         tag_q     <= tag_d;
         data_q    <= data_d;
         wb_way_q  <= wb_way_d;
      end
   end

endmodule

// File: tb/tb_mutative_reconfig_engine.sv
// Directed bench for mutative_reconfig_engine with a behavioural tag/state array and DFP responder.
module tb_mutative_reconfig_engine;
   import mutative_reconfig_engine_pkg::*;

   localparam int W  = 8;
   localparam int S  = 16;
   localparam int LB = 256;
   localparam int TB = 23;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [1:0]      cfg_op;
   logic [1:0]      cfg_setup;
   logic [1:0]      setup;
   logic            flush_stall;
   logic            done;
   logic [3:0]      arr_set;
   logic            arr_rd;
   logic [W-1:0]    arr_valid;
   logic [W-1:0]    arr_dirty;
   logic [W*TB-1:0] arr_tag;
   logic [W*LB-1:0] arr_data;
   logic [W-1:0]    arr_clr_valid;
   logic [W-1:0]    arr_clr_dirty;
   logic [31:0]     dfp_addr;
   logic            dfp_write;
   logic [LB-1:0]   dfp_wdata;
   logic            dfp_resp;

   mutative_reconfig_engine dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_op       (cfg_op),
      .cfg_setup    (cfg_setup),
      .setup        (setup),
      .flush_stall  (flush_stall),
      .done         (done),
      .arr_set      (arr_set),
      .arr_rd       (arr_rd),
      .arr_valid    (arr_valid),
      .arr_dirty    (arr_dirty),
      .arr_tag      (arr_tag),
      .arr_data     (arr_data),
      .arr_clr_valid(arr_clr_valid),
      .arr_clr_dirty(arr_clr_dirty),
      .dfp_addr     (dfp_addr),
      .dfp_write    (dfp_write),
      .dfp_wdata    (dfp_wdata),
      .dfp_resp     (dfp_resp)
   );

   always #5 clk = ~clk;

   logic [W-1:0] valid_mem [S];
   logic [W-1:0] dirty_mem [S];
   logic [W-1:0] clr_v_log [S];
   logic [W-1:0] clr_d_log [S];
   logic [31:0]  wb_addr [4];
   logic [31:0]  wb_data0 [4];
   int           rd_cnt, done_cnt, wr_starts, last_gap, low_cnt, resp_cnt;
   logic         prev_wr;
   bit           resp_en;
   int           n_chk = 0;
   int           n_err = 0;
   int           cyc;

   // Array model and write-back responder; all on the falling edge, away from DUT updates.
   // Tag of (set s, way w) is 0x40000 | s<<4 | w; line word is s*256 + w repeated.
   always @(negedge clk) begin
      if (arr_rd) begin
         arr_valid = valid_mem[arr_set];
         arr_dirty = dirty_mem[arr_set];
         for (int w = 0; w < W; w++) begin
            arr_tag[w*TB +: TB]  = 23'h40000 | 23'({arr_set, 4'(w)});
            arr_data[w*LB +: LB] = {8{{20'd0, arr_set, 8'(w)}}};
         end
         rd_cnt++;
      end
      if (|arr_clr_valid || |arr_clr_dirty) begin
         clr_v_log[arr_set] = arr_clr_valid;
         clr_d_log[arr_set] = arr_clr_dirty;
         valid_mem[arr_set] = valid_mem[arr_set] & ~arr_clr_valid;
         dirty_mem[arr_set] = dirty_mem[arr_set] & ~arr_clr_dirty;
      end
      if (done) done_cnt++;
      if (dfp_write) begin
         if (!prev_wr) begin
            if (wr_starts > 0) last_gap = low_cnt;
            if (wr_starts < 4) begin
               wb_addr[wr_starts]  = dfp_addr;
               wb_data0[wr_starts] = dfp_wdata[31:0];
            end
            wr_starts++;
         end
         low_cnt = 0;
      end else begin
         low_cnt++;
      end
      prev_wr = dfp_write;
      // Respond on the second write cycle, so each WB state lasts two cycles.
      if (dfp_resp) begin
         dfp_resp = 1'b0;
      end else if (dfp_write && resp_en) begin
         if (resp_cnt == 1) begin
            dfp_resp = 1'b1;
            resp_cnt = 0;
         end else begin
            resp_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      rd_cnt    = 0;
      done_cnt  = 0;
      wr_starts = 0;
      last_gap  = -1;
      low_cnt   = 0;
      resp_cnt  = 0;
      prev_wr   = 1'b0;
      for (int s = 0; s < S; s++) begin
         clr_v_log[s] = '0;
         clr_d_log[s] = '0;
      end
      for (int i = 0; i < 4; i++) begin
         wb_addr[i]  = '0;
         wb_data0[i] = '0;
      end
   endtask

   task automatic init_mem(input logic [W-1:0] v, input logic [W-1:0] d);
      for (int s = 0; s < S; s++) begin
         valid_mem[s] = v;
         dirty_mem[s] = d;
      end
   endtask

   // Issues one op and counts cycles from the handshake edge until done is seen (-1 on timeout).
   task automatic run_op(input logic [1:0] op, input logic [1:0] su, output int c);
      cfg_op    = op;
      cfg_setup = su;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      c = 1;
      while (!done && c < 2000) begin
         tick();
         c++;
      end
      if (!done) c = -1;
   endtask

   initial begin
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_op    = 2'd0;
      cfg_setup = 2'd0;
      dfp_resp  = 1'b0;
      resp_en   = 1'b1;
      arr_valid = '0;
      arr_dirty = '0;
      arr_tag   = '0;
      arr_data  = '0;
      init_mem('0, '0);
      clear_logs();
      repeat (3) tick();
      rst = 1'b0;

      check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      check("rst_flush_stall", 64'(flush_stall), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_setup", 64'(setup), 64'd0);
      check("rst_dfp_write", 64'(dfp_write), 64'd0);
      check("rst_arr_rd", 64'(arr_rd), 64'd0);
      check("rst_clr", 64'({arr_clr_valid, arr_clr_dirty}), 64'd0);
      check("rst_dfp_addr", 64'(dfp_addr), 64'd0);

      // INVALIDATE, all clean except set 9 which is dirty: no write-backs either way.
      init_mem(8'hA5, 8'h00);
      valid_mem[9] = 8'hFF;
      dirty_mem[9] = 8'h0F;
      clear_logs();
      run_op(OpInvalidate, 2'd0, cyc);
      check("inv_latency", 64'(cyc), 64'd65);
      check("inv_done_stall", 64'(flush_stall), 64'd1);
      check("inv_done_ready", 64'(cfg_ready), 64'd0);
      tick();
      check("inv_ready_after", 64'(cfg_ready), 64'd1);
      check("inv_no_wb", 64'(wr_starts), 64'd0);
      check("inv_rd_cnt", 64'(rd_cnt), 64'd16);
      check("inv_done_cnt", 64'(done_cnt), 64'd1);
      check("inv_clr_v_set5", 64'(clr_v_log[5]), 64'hA5);
      check("inv_clr_d_set9", 64'(clr_d_log[9]), 64'h00);
      check("inv_mem_valid9", 64'(valid_mem[9]), 64'h00);
      check("inv_setup", 64'(setup), 64'd0);

      // CLEAN with ways 1 and 5 of set 3 dirty: two write-backs, lowest way first.
      init_mem(8'hFF, 8'h00);
      dirty_mem[3] = 8'h22;
      clear_logs();
      run_op(OpClean, 2'd0, cyc);
      check("clean_latency", 64'(cyc), 64'd71);
      tick();
      check("clean_wb_cnt", 64'(wr_starts), 64'd2);
      check("clean_wb0_addr", 64'(wb_addr[0]), 64'h0800_6260);
      check("clean_wb1_addr", 64'(wb_addr[1]), 64'h0800_6A60);
      check("clean_wb0_data", 64'(wb_data0[0]), 64'h0000_0301);
      check("clean_wb1_data", 64'(wb_data0[1]), 64'h0000_0305);
      check("clean_wr_gap", 64'(last_gap), 64'd1);
      check("clean_clr_d_set3", 64'(clr_d_log[3]), 64'h22);
      check("clean_clr_v_set3", 64'(clr_v_log[3]), 64'h00);
      check("clean_mem_dirty3", 64'(dirty_mem[3]), 64'h00);
      check("clean_mem_valid3", 64'(valid_mem[3]), 64'hFF);

      // Dirty but invalid way 2 in set 6 is never written back.
      init_mem(8'hFF, 8'h00);
      valid_mem[6] = 8'hFB;
      dirty_mem[6] = 8'h04;
      clear_logs();
      run_op(OpClean, 2'd0, cyc);
      check("dinv_latency", 64'(cyc), 64'd65);
      tick();
      check("dinv_no_wb", 64'(wr_starts), 64'd0);
      check("dinv_clr_d_set6", 64'(clr_d_log[6]), 64'h04);

      // RESIZE 0 -> 2 performs a full CLEAN_INV walk; set 10 way 7 is dirty.
      init_mem(8'h00, 8'h00);
      valid_mem[10] = 8'hFF;
      dirty_mem[10] = 8'h80;
      clear_logs();
      run_op(OpResize, 2'd2, cyc);
      check("rsz_latency", 64'(cyc), 64'd68);
      check("rsz_setup_at_done", 64'(setup), 64'd2);
      tick();
      check("rsz_wb_cnt", 64'(wr_starts), 64'd1);
      check("rsz_wb0_addr", 64'(wb_addr[0]), 64'h0801_4F40);
      check("rsz_clr_v_set10", 64'(clr_v_log[10]), 64'hFF);
      check("rsz_clr_d_set10", 64'(clr_d_log[10]), 64'h80);
      check("rsz_mem_valid10", 64'(valid_mem[10]), 64'h00);
      check("rsz_rd_cnt", 64'(rd_cnt), 64'd16);

      // RESIZE to the current setting completes without reading the arrays.
      clear_logs();
      run_op(OpResize, 2'd2, cyc);
      check("rsz_same_fast", 64'(cyc >= 1 && cyc <= 2), 64'd1);
      tick();
      check("rsz_same_no_rd", 64'(rd_cnt), 64'd0);
      check("rsz_same_setup", 64'(setup), 64'd2);
      check("rsz_same_done_cnt", 64'(done_cnt), 64'd1);

      // RESIZE to the largest encodable setting (8 ways -> 3).
      clear_logs();
      run_op(OpResize, 2'd3, cyc);
      check("rsz_max_latency", 64'(cyc), 64'd65);
      check("rsz_max_setup", 64'(setup), 64'd3);
      tick();

      // A request while busy is dropped: one done, and no INVALIDATE of the valid bits.
      init_mem(8'h3C, 8'h00);
      clear_logs();
      cfg_op    = OpClean;
      cfg_setup = 2'd0;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      repeat (4) tick();
      check("busy_ready", 64'(cfg_ready), 64'd0);
      check("busy_stall", 64'(flush_stall), 64'd1);
      cfg_op    = OpInvalidate;
      cfg_valid = 1'b1;
      repeat (3) tick();
      cfg_valid = 1'b0;
      cyc = 8;
      while (!done && cyc < 2000) begin
         tick();
         cyc++;
      end
      check("busy_latency", 64'(cyc), 64'd65);
      repeat (10) tick();
      check("busy_done_cnt", 64'(done_cnt), 64'd1);
      check("busy_valid_kept", 64'(valid_mem[0]), 64'h3C);
      check("busy_ready_after", 64'(cfg_ready), 64'd1);

      // Reset during a write-back aborts at once and leaves the arrays alone.
      init_mem(8'h00, 8'h00);
      valid_mem[0] = 8'h01;
      dirty_mem[0] = 8'h01;
      clear_logs();
      resp_en   = 1'b0;
      cfg_op    = OpClean;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      cyc = 0;
      while (!dfp_write && cyc < 50) begin
         tick();
         cyc++;
      end
      check("rstwb_in_wb", 64'(dfp_write), 64'd1);
      check("rstwb_addr", 64'(dfp_addr), 64'h0800_0000);
      rst = 1'b1;
      tick();
      check("rstwb_dfp_write", 64'(dfp_write), 64'd0);
      check("rstwb_stall", 64'(flush_stall), 64'd0);
      check("rstwb_ready", 64'(cfg_ready), 64'd1);
      check("rstwb_setup", 64'(setup), 64'd0);
      rst = 1'b0;
      tick();
      check("rstwb_no_done", 64'(done_cnt), 64'd0);
      check("rstwb_mem_dirty0", 64'(dirty_mem[0]), 64'h01);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
